// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer/flag controller for a dual-clock FIFO: binary/Gray write
// pointer, read-pointer synchronizer, and registered full/almost-full/level/overflow.
module wptr_full_ctrl #(
    parameter int unsigned ADDRSIZE     = 4,
    parameter int unsigned AFULL_THRESH = 12,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic                wovf_clr,
    input  logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE:0]   wptr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic                wclken,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbinnext;
    logic [PW-1:0] wgraynext;
    logic [PW-1:0] wq [SYNC_STAGES];
    logic [PW-1:0] wqs;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] wlevel_next;
    logic          accepted;
    logic          wfull_next;
    logic          walmost_full_next;
    logic          rejected;

    assign waddr    = wbin[ADDRSIZE-1:0];
    assign accepted = winc & ~wfull;
    assign rejected = winc & wfull;
    // Reset masks the write strobe so the memory never sees a write while held in reset
    assign wclken   = accepted & wrst_n;
    assign wqs      = wq[SYNC_STAGES-1];

    always_comb begin
        wbinnext  = wbin + PW'(accepted);
        wgraynext = (wbinnext >> 1) ^ wbinnext;
    end

    // Gray-to-binary of the synchronized read pointer
    always_comb begin
        rbin_s         = '0;
        rbin_s[PW-1]   = wqs[PW-1];
        for (int i = int'(PW) - 2; i >= 0; i--) begin
            rbin_s[i] = rbin_s[i+1] ^ wqs[i];
        end
    end

    always_comb begin
        wlevel_next       = wbinnext - rbin_s;
        wfull_next        = (wgraynext == {~wqs[PW-1:PW-2], wqs[PW-3:0]});
        walmost_full_next = (wlevel_next >= PW'(AFULL_THRESH));
    end

    // Read-pointer synchronizer: plain flop chain, no logic between stages
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                wq[i] <= '0;
            end
        end else begin
            wq[0] <= rptr;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                wq[i] <= wq[i-1];
            end
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= wfull_next;
            walmost_full <= walmost_full_next;
            wlevel       <= wlevel_next;
        end
    end

    // Sticky overflow; a rejected write in the same cycle beats the clear
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            woverflow <= 1'b0;
        end else if (rejected) begin
            woverflow <= 1'b1;
        end else if (wovf_clr) begin
            woverflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl: reset, fill, overflow, drain latency, wrap, mid-fill reset.
module tb_wptr_full_ctrl;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic       wovf_clr;
    logic [4:0] rptr;
    logic [4:0] wptr;
    logic [3:0] waddr;
    logic       wclken;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       woverflow;

    int n_vec;
    int n_err;

    wptr_full_ctrl #(
        .ADDRSIZE    (4),
        .AFULL_THRESH(12),
        .SYNC_STAGES (2)
    ) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .winc        (winc),
        .wovf_clr    (wovf_clr),
        .rptr        (rptr),
        .wptr        (wptr),
        .waddr       (waddr),
        .wclken      (wclken),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .wlevel      (wlevel),
        .woverflow   (woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] gray(input logic [4:0] b);
        return (b >> 1) ^ b;
    endfunction

    task automatic apply_reset();
        winc     = 1'b0;
        wovf_clr = 1'b0;
        rptr     = 5'd0;
        wrst_n   = 1'b0;
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wclken"}, 32'(wclken), 32'd0);
        check({tag, ".wptr"}, 32'(wptr), 32'd0);
        check({tag, ".waddr"}, 32'(waddr), 32'd0);
        check({tag, ".wfull"}, 32'(wfull), 32'd0);
        check({tag, ".walmost_full"}, 32'(walmost_full), 32'd0);
        check({tag, ".wlevel"}, 32'(wlevel), 32'd0);
        check({tag, ".woverflow"}, 32'(woverflow), 32'd0);
    endtask

    initial begin
        logic [4:0] prev_ptr;
        n_vec    = 0;
        n_err    = 0;
        wrst_n   = 1'b0;
        winc     = 1'b1;
        wovf_clr = 1'b0;
        rptr     = 5'd0;

        // Reset with write requested: strobe masked, everything zero
        #1;
        check_all_zero("rst");
        @(posedge wclk);
        #1;
        check_all_zero("rst_edge");
        @(negedge wclk);
        wrst_n = 1'b1;
        winc   = 1'b0;

        // Fill 16 entries with the reader idle
        for (int i = 0; i < 16; i++) begin
            @(negedge wclk);
            winc = 1'b1;
            #1;
            check("fill.waddr", 32'(waddr), 32'(i));
            check("fill.wclken", 32'(wclken), 32'd1);
            @(posedge wclk);
            #1;
            check("fill.wlevel", 32'(wlevel), 32'(i + 1));
            check("fill.walmost_full", 32'(walmost_full), (i + 1 >= 12) ? 32'd1 : 32'd0);
            check("fill.wfull", 32'(wfull), (i == 15) ? 32'd1 : 32'd0);
        end
        check("fill.wptr", 32'(wptr), 32'b11000);
        check("fill.waddr_wrap", 32'(waddr), 32'd0);

        // Overflow: two rejected writes
        @(negedge wclk);
        winc = 1'b1;
        #1;
        check("ovf.wclken", 32'(wclken), 32'd0);
        repeat (2) @(posedge wclk);
        #1;
        check("ovf.wptr", 32'(wptr), 32'b11000);
        check("ovf.woverflow", 32'(woverflow), 32'd1);
        check("ovf.wlevel", 32'(wlevel), 32'd16);
        @(negedge wclk);
        wovf_clr = 1'b1;
        @(posedge wclk);
        #1;
        check("ovf.set_beats_clr", 32'(woverflow), 32'd1);
        @(negedge wclk);
        winc = 1'b0;
        @(posedge wclk);
        #1;
        check("ovf.cleared", 32'(woverflow), 32'd0);
        @(negedge wclk);
        wovf_clr = 1'b0;

        // Drain visibility: one read seen three edges later
        rptr = 5'b00001;
        repeat (2) begin
            @(posedge wclk);
            #1;
            check("drain.wfull_held", 32'(wfull), 32'd1);
            check("drain.wlevel_held", 32'(wlevel), 32'd16);
        end
        @(posedge wclk);
        #1;
        check("drain.wfull", 32'(wfull), 32'd0);
        check("drain.wlevel", 32'(wlevel), 32'd15);
        check("drain.walmost_full", 32'(walmost_full), 32'd1);

        // Reset mid-fill, asserted between edges
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge wclk);
            winc = 1'b1;
            @(posedge wclk);
        end
        #1;
        check("mid.wlevel_pre", 32'(wlevel), 32'd7);
        check("mid.waddr_pre", 32'(waddr), 32'd7);
        @(negedge wclk);
        #2;
        wrst_n = 1'b0;
        #1;
        check_all_zero("mid");
        @(negedge wclk);
        wrst_n = 1'b1;
        #1;
        check("mid.first_waddr", 32'(waddr), 32'd0);
        check("mid.first_wclken", 32'(wclken), 32'd1);
        @(posedge wclk);
        #1;
        check("mid.first_wptr", 32'(wptr), 32'b00001);
        check("mid.next_waddr", 32'(waddr), 32'd1);

        // Wrap: 40 writes, reader trailing the writer by 2
        apply_reset();
        prev_ptr = 5'd0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge wclk);
            winc = 1'b1;
            rptr = (j >= 3) ? gray(5'(j - 3)) : 5'd0;
            #1;
            check("wrap.waddr", 32'(waddr), 32'((j - 1) % 16));
            @(posedge wclk);
            #1;
            check("wrap.wptr", 32'(wptr), 32'(gray(5'(j))));
            check("wrap.one_bit", 32'($countones(wptr ^ prev_ptr)), 32'd1);
            check("wrap.wlevel", 32'(wlevel), 32'((j < 5) ? j : 5));
            check("wrap.wfull", 32'(wfull), 32'd0);
            prev_ptr = wptr;
        end
        @(negedge wclk);
        winc = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-domain pointer and flag controller for the asynchronous FIFO; sits directly upstream of the dual-clock FIFO memory and drives its write address, write enable and full inputs. Keeps the binary/Gray write pointer, synchronizes the read-domain Gray pointer into the write clock, and generates registered full, almost-full, fill-level and sticky overflow status for the producer. Runs entirely in the write clock domain.

## Interface
- ADDRSIZE, 4, memory address width; depth = 2^ADDRSIZE
- AFULL_THRESH, 12, walmost_full asserts when level ≥ this value (1..2^ADDRSIZE)
- SYNC_STAGES, 2, flops in read-pointer synchronizer (≥2)

- wclk  in  1  write clock; all state on rising edge
- wrst_n  in  1  asynchronous active-low reset
- winc  in  1  producer write request this cycle
- wovf_clr  in  1  clear sticky overflow
- rptr  in  ADDRSIZE+1  read pointer, Gray code, from read domain
- wptr  out  ADDRSIZE+1  write pointer, Gray code, registered, to read domain
- waddr  out  ADDRSIZE  memory write address (low bits of binary pointer)
- wclken  out  1  memory write enable = winc & ~wfull
- wfull  out  1  FIFO full, registered
- walmost_full  out  1  level ≥ AFULL_THRESH, registered
- wlevel  out  ADDRSIZE+1  conservative occupancy, 0..2^ADDRSIZE, registered
- woverflow  out  1  sticky: write attempted while full

## Operation
- State: binary pointer wbin and Gray pointer wptr (ADDRSIZE+1 bits each), synchronizer chain wq[1..SYNC_STAGES], flag registers.
- Accepted write: winc & ~wfull. wbinnext = wbin + accepted (mod 2^(ADDRSIZE+1)); wgraynext = (wbinnext >> 1) ^ wbinnext. Both registered each cycle.
- waddr = wbin[ADDRSIZE-1:0]; combinational from register, no extra logic.
- Synchronizer: rptr sampled by wq1, shifted through to wqS (final stage). No logic between stages.
- Full: wfull_next = (wgraynext == {~wqS[MSB:MSB-1], wqS[MSB-2:0]}). Registered.
- Level: rbin_s = Gray-to-binary(wqS); wlevel_next = wbinnext − rbin_s, modulo 2^(ADDRSIZE+1). Registered. Never exceeds 2^ADDRSIZE in legal operation.
- Almost-full: walmost_full_next = (wlevel_next ≥ AFULL_THRESH). Registered.
- Overflow: set when winc & wfull; cleared when wovf_clr & ~(winc & wfull). Set wins over clear in the same cycle. Pointer never moves on a rejected write.
- Flags are pessimistic: read progress is seen late, so wfull/wlevel may overstate occupancy, never understate.
- Reset (async assert, sync release by upstream): wbin=0, wptr=0, all wq=0, waddr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0; wclken=winc during reset is masked to 0.

## Timing
- Write accepted at edge N: waddr, wptr, wlevel update at edge N; wfull/walmost_full reflect the post-write state at edge N (no extra lag).
- wclken is combinational: same cycle as winc.
- Read-pointer change visible in wqS after SYNC_STAGES edges; wfull/wlevel/walmost_full update on the following edge: SYNC_STAGES+1 wclk edges total (3 with default).
- Wrap-around: wbin rolls from 2^(ADDRSIZE+1)−1 to 0; Gray pointer changes one bit per increment including wrap.
- Simultaneous write and read-pointer change: level computed from both in the same cycle; no lost counts.
- Reset mid-operation: all outputs return to reset values immediately on wrst_n low, regardless of clock.

## Test plan
- Reset: drive winc=1 with wrst_n=0 -> wclken=0, wptr=0, waddr=0, wfull=0, wlevel=0, woverflow=0.
- Fill: rptr=0, 16 consecutive writes -> waddr 0..15 then 0; after 16th edge wfull=1, wlevel=16, wptr=5'b11000; walmost_full=1 from the 12th write edge.
- Overflow: full, winc=1 for 2 cycles -> wclken=0, wptr unchanged, woverflow=1 and stays; wovf_clr=1 with winc=0 -> woverflow=0 next edge; wovf_clr with winc&wfull -> woverflow stays 1.
- Drain visibility: full, rptr steps to 5'b00001 -> wfull=0 and wlevel=15 exactly 3 edges later; walmost_full stays 1.
- Wrap: repeated write/read with rptr tracking 2 entries behind over 40 writes -> wbin wraps past 31, wptr changes one bit per write, wlevel steady at 2 (plus sync lag), wfull never set.
- Reset mid-fill: after 7 writes assert wrst_n low asynchronously between edges -> all outputs zero at once; after release first write lands at waddr=0.
